// File: rtl/mcyc_ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcyc_ctrl_fsm_pkg
//  Description : Shared constants for the multi-cycle MIPS-style controller.
//                Holds state codes, opcode/func fields, ALU operation codes,
//                ALU B-operand and PC-source encodings, fault causes, and the
//                DECODE dispatch helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcyc_ctrl_fsm_pkg;

    // Controller state codes.
    localparam logic [3:0] c_st_fetch  = 4'd0;
    localparam logic [3:0] c_st_decode = 4'd1;
    localparam logic [3:0] c_st_exec_r = 4'd2;
    localparam logic [3:0] c_st_exec_i = 4'd3;
    localparam logic [3:0] c_st_addr   = 4'd4;
    localparam logic [3:0] c_st_mem_rd = 4'd5;
    localparam logic [3:0] c_st_mem_wr = 4'd6;
    localparam logic [3:0] c_st_wb_r   = 4'd7;
    localparam logic [3:0] c_st_wb_i   = 4'd8;
    localparam logic [3:0] c_st_wb_mem = 4'd9;
    localparam logic [3:0] c_st_branch = 4'd10;
    localparam logic [3:0] c_st_jump   = 4'd11;
    localparam logic [3:0] c_st_jr     = 4'd12;
    localparam logic [3:0] c_st_fault  = 4'd13;

    // Opcodes.
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    // R-type function fields.
    localparam logic [5:0] c_fn_sll = 6'h00;
    localparam logic [5:0] c_fn_jr  = 6'h08;
    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_or  = 6'h25;
    localparam logic [5:0] c_fn_slt = 6'h2A;

    // ALU operation codes.
    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [3:0] c_alu_sll = 4'b1000;

    // ALU B-operand select.
    localparam logic [2:0] c_srcb_regb    = 3'd0;
    localparam logic [2:0] c_srcb_shamt   = 3'd1;
    localparam logic [2:0] c_srcb_sext    = 3'd2;
    localparam logic [2:0] c_srcb_sext_s2 = 3'd3;
    localparam logic [2:0] c_srcb_four    = 3'd4;
    localparam logic [2:0] c_srcb_zext    = 3'd5;

    // PC source select.
    localparam logic [1:0] c_pc_alu    = 2'd0;
    localparam logic [1:0] c_pc_aluout = 2'd1;
    localparam logic [1:0] c_pc_jump   = 2'd2;
    localparam logic [1:0] c_pc_rega   = 2'd3;

    // Fault causes.
    localparam logic [1:0] c_cause_none    = 2'd0;
    localparam logic [1:0] c_cause_illegal = 2'd1;
    localparam logic [1:0] c_cause_timeout = 2'd2;

    // State that follows DECODE for a given instruction; unsupported
    // encodings dispatch to FAULT.
    function automatic logic [3:0] decode_target(input logic [5:0] op,
                                                 input logic [5:0] func);
        logic [3:0] nxt;
        nxt = c_st_fault;
        case (op)
            c_op_rtype: begin
                case (func)
                    c_fn_add, c_fn_sub, c_fn_and,
                    c_fn_or, c_fn_slt, c_fn_sll: nxt = c_st_exec_r;
                    c_fn_jr:                     nxt = c_st_jr;
                    default:                     nxt = c_st_fault;
                endcase
            end
            c_op_addi, c_op_andi, c_op_ori: nxt = c_st_exec_i;
            c_op_lw, c_op_sw:               nxt = c_st_addr;
            c_op_beq, c_op_bne:             nxt = c_st_branch;
            c_op_j:                         nxt = c_st_jump;
            default:                        nxt = c_st_fault;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcyc_ctrl_fsm_alu_dec.sv
`default_nettype none
// ============================================================================
//  Module      : mcyc_alu_dec
//  Description : ALU operation decoder for the multi-cycle controller.
//                Ports: i_state (controller state), i_op / i_func
//                (instruction fields) -> o_alu_op (ALU operation code).
//  Revision    : 1.0 - initial release
// ============================================================================
module mcyc_alu_dec
    import mcyc_ctrl_fsm_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output logic [3:0] o_alu_op
);

    always_comb begin
        o_alu_op = c_alu_and;
        case (i_state)
            c_st_fetch, c_st_decode, c_st_addr: o_alu_op = c_alu_add;
            c_st_exec_r: begin
                case (i_func)
                    c_fn_add: o_alu_op = c_alu_add;
                    c_fn_sub: o_alu_op = c_alu_sub;
                    c_fn_and: o_alu_op = c_alu_and;
                    c_fn_or:  o_alu_op = c_alu_or;
                    c_fn_slt: o_alu_op = c_alu_slt;
                    c_fn_sll: o_alu_op = c_alu_sll;
                    default:  o_alu_op = c_alu_and;
                endcase
            end
            c_st_exec_i: begin
                case (i_op)
                    c_op_addi: o_alu_op = c_alu_add;
                    c_op_andi: o_alu_op = c_alu_and;
                    c_op_ori:  o_alu_op = c_alu_or;
                    default:   o_alu_op = c_alu_and;
                endcase
            end
            c_st_branch: o_alu_op = c_alu_sub;
            default:     o_alu_op = c_alu_and;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mcyc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mcyc_ctrl_fsm
//  Description : Multi-cycle MIPS-subset control unit with a memory wait
//                timeout and a sticky fault state.
//                Inputs : clk, rst (sync, active-high), op, func, zero,
//                         mem_ready.
//                Outputs: register load enables, register-file write and
//                         datapath selects, PC/memory controls, state code,
//                         fault and fault_cause.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcyc_ctrl_fsm
    import mcyc_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       rega_we,
    output logic       regb_we,
    output logic       alu_out_we,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [2:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] state,
    output logic       fault,
    output logic [1:0] fault_cause
);

    // Counter value on the last permitted wait cycle.
    localparam logic [TO_W-1:0] c_to_last =
        (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;
    localparam logic [TO_W-1:0] c_cnt_max = {TO_W{1'b1}};

    logic [3:0]      r_state;
    logic [TO_W-1:0] r_wait_cnt;
    logic [1:0]      r_fault_cause;

    logic [3:0]      w_next_state;
    logic [1:0]      w_next_cause;
    logic [TO_W-1:0] w_next_cnt;
    logic            w_in_wait;
    logic            w_next_in_wait;
    logic            w_timeout;

    assign w_in_wait      = (r_state == c_st_fetch) || (r_state == c_st_mem_rd) ||
                            (r_state == c_st_mem_wr);
    assign w_next_in_wait = (w_next_state == c_st_fetch) ||
                            (w_next_state == c_st_mem_rd) ||
                            (w_next_state == c_st_mem_wr);
    // mem_ready in the final wait cycle still wins over the timeout.
    assign w_timeout      = (MEM_TIMEOUT > 0) && w_in_wait && !mem_ready &&
                            (r_wait_cnt == c_to_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cause = r_fault_cause;
        case (r_state)
            c_st_fetch: begin
                if (mem_ready) begin
                    w_next_state = c_st_decode;
                end else if (w_timeout) begin
                    w_next_state = c_st_fault;
                    w_next_cause = c_cause_timeout;
                end
            end
            c_st_decode: begin
                w_next_state = decode_target(op, func);
                if (w_next_state == c_st_fault) begin
                    w_next_cause = c_cause_illegal;
                end
            end
            c_st_exec_r: w_next_state = c_st_wb_r;
            c_st_exec_i: w_next_state = c_st_wb_i;
            c_st_addr:   w_next_state = (op == c_op_sw) ? c_st_mem_wr : c_st_mem_rd;
            c_st_mem_rd: begin
                if (mem_ready) begin
                    w_next_state = c_st_wb_mem;
                end else if (w_timeout) begin
                    w_next_state = c_st_fault;
                    w_next_cause = c_cause_timeout;
                end
            end
            c_st_mem_wr: begin
                if (mem_ready) begin
                    w_next_state = c_st_fetch;
                end else if (w_timeout) begin
                    w_next_state = c_st_fault;
                    w_next_cause = c_cause_timeout;
                end
            end
            c_st_wb_r, c_st_wb_i, c_st_wb_mem,
            c_st_branch, c_st_jump, c_st_jr: w_next_state = c_st_fetch;
            c_st_fault:  w_next_state = c_st_fault;
            // Unused codes recover through a fresh fetch.
            default:     w_next_state = c_st_fetch;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory wait counter
    // ------------------------------------------------------------------
    always_comb begin
        w_next_cnt = r_wait_cnt;
        if (w_next_in_wait && (w_next_state != r_state)) begin
            w_next_cnt = '0;
        end else if (mem_ready) begin
            w_next_cnt = '0;
        end else if (w_in_wait && (r_wait_cnt != c_cnt_max)) begin
            w_next_cnt = r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_fetch;
            r_wait_cnt    <= '0;
            r_fault_cause <= c_cause_none;
        end else begin
            r_state       <= w_next_state;
            r_wait_cnt    <= w_next_cnt;
            r_fault_cause <= w_next_cause;
        end
    end

    // ------------------------------------------------------------------
    // ALU operation decode
    // ------------------------------------------------------------------
    mcyc_alu_dec u_alu_dec (
        .i_state  (r_state),
        .i_op     (op),
        .i_func   (func),
        .o_alu_op (alu_op)
    );

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        rega_we    = 1'b0;
        regb_we    = 1'b0;
        alu_out_we = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = c_srcb_regb;
        pc_src     = c_pc_alu;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (r_state)
            c_st_fetch: begin
                mem_read  = 1'b1;
                alu_src_b = c_srcb_four;
                ir_we     = mem_ready;
                pc_write  = mem_ready;
            end
            c_st_decode: begin
                alu_src_b  = c_srcb_sext_s2;
                alu_out_we = 1'b1;
                rega_we    = 1'b1;
                regb_we    = 1'b1;
            end
            c_st_exec_r: begin
                alu_src_a  = 1'b1;
                alu_out_we = 1'b1;
                alu_src_b  = (func == c_fn_sll) ? c_srcb_shamt : c_srcb_regb;
            end
            c_st_wb_r: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            c_st_exec_i: begin
                alu_src_a  = 1'b1;
                alu_out_we = 1'b1;
                alu_src_b  = (op == c_op_addi) ? c_srcb_sext : c_srcb_zext;
            end
            c_st_wb_i: reg_write = 1'b1;
            c_st_addr: begin
                alu_src_a  = 1'b1;
                alu_src_b  = c_srcb_sext;
                alu_out_we = 1'b1;
            end
            c_st_mem_rd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                mdr_we   = mem_ready;
            end
            c_st_mem_wr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            c_st_wb_mem: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            c_st_branch: begin
                alu_src_a = 1'b1;
                pc_src    = c_pc_aluout;
                pc_write  = ((op == c_op_beq) && zero) || ((op == c_op_bne) && !zero);
            end
            c_st_jump: begin
                pc_src   = c_pc_jump;
                pc_write = 1'b1;
            end
            c_st_jr: begin
                pc_src   = c_pc_rega;
                pc_write = 1'b1;
            end
            default: ;
        endcase

        // Nothing may write or strobe memory while reset is held.
        if (rst) begin
            ir_we      = 1'b0;
            mdr_we     = 1'b0;
            rega_we    = 1'b0;
            regb_we    = 1'b0;
            alu_out_we = 1'b0;
            reg_write  = 1'b0;
            pc_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
        end
    end

    assign state       = r_state;
    assign fault       = (r_state == c_st_fault);
    assign fault_cause = (r_state == c_st_fault) ? r_fault_cause : c_cause_none;

endmodule
`default_nettype wire

// File: tb/tb_mcyc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcyc_ctrl_fsm
//  Description : Self-checking bench for mcyc_ctrl_fsm. Each instruction is
//                expanded into a planned per-cycle trace (phase, mem_ready,
//                rst) from the instruction class and chosen wait counts; the
//                expected control word for every cycle is derived from the
//                phase and compared against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcyc_ctrl_fsm;
    import mcyc_ctrl_fsm_pkg::*;

    typedef struct packed {
        logic       ir_we, mdr_we, rega_we, regb_we, alu_out_we;
        logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [2:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write, iord, mem_read, mem_write;
        logic [3:0] state;
        logic       fault;
        logic [1:0] fault_cause;
    } ctl_t;

    typedef struct {
        logic [3:0] ph;
        logic       rdy;
    } cyc_t;

    logic       clk, rst, zero, mem_ready;
    logic [5:0] op, func;
    logic       ir_we, mdr_we, rega_we, regb_we, alu_out_we, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, pc_write, iord, mem_read, mem_write;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op, state;
    logic [1:0] pc_src, fault_cause;
    logic       fault;
    ctl_t       obs;

    int n_checks = 0;
    int n_errors = 0;
    int g_rd     = 0;
    int g_mdr    = 0;
    int g_regw   = 0;

    logic [5:0] t_op [0:16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05,
                                6'h02, 6'h3F, 6'h00};
    logic [5:0] t_fn [0:16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08,
                                6'h11, 6'h00, 6'h3F, 6'h05, 6'h07, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h01};

    mcyc_ctrl_fsm #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .ir_we(ir_we), .mdr_we(mdr_we),
        .rega_we(rega_we), .regb_we(regb_we), .alu_out_we(alu_out_we),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .pc_write(pc_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .state(state),
        .fault(fault), .fault_cause(fault_cause)
    );

    assign obs = {ir_we, mdr_we, rega_we, regb_we, alu_out_we, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
                  pc_write, iord, mem_read, mem_write, state, fault, fault_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b1000;
        endcase
    endfunction

    // Expected control word for one cycle in the given phase.
    function automatic ctl_t exp_ctl(input logic [3:0] ph, input logic [5:0] o,
                                     input logic [5:0] f, input logic z,
                                     input logic rdy, input logic r,
                                     input logic [1:0] cause);
        ctl_t c;
        c = '0;
        c.state = ph;
        case (ph)
            c_st_fetch: begin
                c.mem_read = 1; c.alu_src_b = 3'd4; c.alu_op = 4'b0010;
                c.ir_we = rdy; c.pc_write = rdy;
            end
            c_st_decode: begin
                c.alu_src_b = 3'd3; c.alu_op = 4'b0010;
                c.alu_out_we = 1; c.rega_we = 1; c.regb_we = 1;
            end
            c_st_exec_r: begin
                c.alu_src_a = 1; c.alu_out_we = 1; c.alu_op = r_alu(f);
                c.alu_src_b = (f == 6'h00) ? 3'd1 : 3'd0;
            end
            c_st_wb_r: begin c.reg_dst = 1; c.reg_write = 1; end
            c_st_exec_i: begin
                c.alu_src_a = 1; c.alu_out_we = 1;
                if (o == 6'h08) begin c.alu_src_b = 3'd2; c.alu_op = 4'b0010; end
                else begin
                    c.alu_src_b = 3'd5;
                    c.alu_op = (o == 6'h0C) ? 4'b0000 : 4'b0001;
                end
            end
            c_st_wb_i: c.reg_write = 1;
            c_st_addr: begin
                c.alu_src_a = 1; c.alu_src_b = 3'd2; c.alu_op = 4'b0010;
                c.alu_out_we = 1;
            end
            c_st_mem_rd: begin c.mem_read = 1; c.iord = 1; c.mdr_we = rdy; end
            c_st_mem_wr: begin c.mem_write = 1; c.iord = 1; end
            c_st_wb_mem: begin c.mem_to_reg = 1; c.reg_write = 1; end
            c_st_branch: begin
                c.alu_src_a = 1; c.alu_op = 4'b0110; c.pc_src = 2'd1;
                c.pc_write = (o == 6'h04) ? z : ~z;
            end
            c_st_jump: begin c.pc_src = 2'd2; c.pc_write = 1; end
            c_st_jr:   begin c.pc_src = 2'd3; c.pc_write = 1; end
            c_st_fault: begin c.fault = 1; c.fault_cause = cause; end
            default: ;
        endcase
        if (r) begin
            c.ir_we = 0; c.mdr_we = 0; c.rega_we = 0; c.regb_we = 0;
            c.alu_out_we = 0; c.reg_write = 0; c.pc_write = 0;
            c.mem_read = 0; c.mem_write = 0;
        end
        return c;
    endfunction

    // One clock cycle: drive inputs just after the edge, compare mid-cycle.
    task automatic step(input logic [3:0] ph, input logic rdy, input logic r,
                        input logic [5:0] o, input logic [5:0] f,
                        input logic [1:0] cause, input int zsel, input string tag);
        logic z;
        z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
        op = o; func = f; mem_ready = rdy; rst = r; zero = z;
        #4;
        check(tag, 32'(obs), 32'(exp_ctl(ph, o, f, z, rdy, r, cause)));
        if (state == c_st_mem_rd) g_rd++;
        if (mdr_we) g_mdr++;
        if (reg_write) g_regw++;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_wait(input int w);
        if (w >= 0) return w;
        return ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
    endfunction

    // Runs one instruction. wf/wm: fetch/memory wait cycles (4 = timeout,
    // -1 = random). abort_at: plan index at which rst is raised (-1 none,
    // -2 random). hold: cycles observed in FAULT before reset.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int wf, input int wm, input int zsel,
                             input int abort_at, input int hold, input string tag);
        cyc_t       plan[$];
        logic [1:0] cause;
        bit         faulted;
        int         nf, nm, ab;
        cause = 2'd0; faulted = 0;
        nf = pick_wait(wf);
        nm = pick_wait(wm);
        for (int i = 0; i < nf && i < 4; i++) plan.push_back('{c_st_fetch, 1'b0});
        if (nf >= 4) begin
            faulted = 1; cause = 2'd2;
        end else begin
            plan.push_back('{c_st_fetch, 1'b1});
            plan.push_back('{c_st_decode, 1'($urandom_range(0, 1))});
            case (o)
                6'h00: begin
                    if (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00}) begin
                        plan.push_back('{c_st_exec_r, 1'($urandom_range(0, 1))});
                        plan.push_back('{c_st_wb_r, 1'($urandom_range(0, 1))});
                    end else if (f == 6'h08) begin
                        plan.push_back('{c_st_jr, 1'($urandom_range(0, 1))});
                    end else begin
                        faulted = 1; cause = 2'd1;
                    end
                end
                6'h08, 6'h0C, 6'h0D: begin
                    plan.push_back('{c_st_exec_i, 1'($urandom_range(0, 1))});
                    plan.push_back('{c_st_wb_i, 1'($urandom_range(0, 1))});
                end
                6'h23, 6'h2B: begin
                    logic [3:0] mph;
                    mph = (o == 6'h23) ? c_st_mem_rd : c_st_mem_wr;
                    plan.push_back('{c_st_addr, 1'($urandom_range(0, 1))});
                    for (int i = 0; i < nm && i < 4; i++) plan.push_back('{mph, 1'b0});
                    if (nm >= 4) begin
                        faulted = 1; cause = 2'd2;
                    end else begin
                        plan.push_back('{mph, 1'b1});
                        if (o == 6'h23) plan.push_back('{c_st_wb_mem, 1'($urandom_range(0, 1))});
                    end
                end
                6'h04, 6'h05: plan.push_back('{c_st_branch, 1'($urandom_range(0, 1))});
                6'h02:        plan.push_back('{c_st_jump, 1'($urandom_range(0, 1))});
                default: begin faulted = 1; cause = 2'd1; end
            endcase
        end
        ab = abort_at;
        if (ab == -2)
            ab = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, plan.size() - 1)) : -1;
        foreach (plan[i]) begin
            if (i == ab) begin
                step(plan[i].ph, plan[i].rdy, 1'b1, o, f, 2'd0, zsel, {tag, "_rst"});
                return;
            end
            step(plan[i].ph, plan[i].rdy, 1'b0, o, f, 2'd0, zsel, tag);
        end
        if (faulted) begin
            for (int k = 0; k < hold; k++)
                step(c_st_fault, 1'($urandom_range(0, 1)), 1'b0, o, f, cause, zsel,
                     {tag, "_fault"});
            step(c_st_fault, 1'($urandom_range(0, 1)), 1'b1, o, f, cause, zsel,
                 {tag, "_fault_rst"});
        end
    endtask

    initial begin
        int idx;
        rst = 1'b1; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Reset state, held for two cycles with mem_ready high.
        step(c_st_fetch, 1'b1, 1'b1, 6'h00, 6'h20, 2'd0, 0, "reset");
        step(c_st_fetch, 1'b1, 1'b1, 6'h00, 6'h20, 2'd0, 0, "reset");

        g_regw = 0;
        run_instr(6'h00, 6'h20, 0, 0, -1, -1, 0, "add");
        check("add_regw_count", 32'(g_regw), 32'd1);

        g_rd = 0; g_mdr = 0;
        run_instr(6'h23, 6'h00, 0, 3, -1, -1, 0, "lw_wait3");
        check("lw_mem_rd_cycles", 32'(g_rd), 32'd4);
        check("lw_mdr_pulses", 32'(g_mdr), 32'd1);

        run_instr(6'h04, 6'h00, 0, 0, 1, -1, 0, "beq_z1");
        run_instr(6'h05, 6'h00, 0, 0, 1, -1, 0, "bne_z1");
        run_instr(6'h04, 6'h00, 0, 0, 0, -1, 0, "beq_z0");
        run_instr(6'h3F, 6'h00, 0, 0, -1, -1, 10, "illegal");
        run_instr(6'h00, 6'h20, 0, 0, -1, -1, 0, "after_illegal");
        run_instr(6'h08, 6'h00, 4, 0, -1, -1, 2, "fetch_timeout");
        run_instr(6'h08, 6'h00, 3, 0, -1, -1, 0, "fetch_ready_last");
        run_instr(6'h2B, 6'h00, 0, 4, -1, -1, 2, "sw_timeout");
        run_instr(6'h2B, 6'h00, 0, 3, -1, 4, 0, "sw_abort");
        run_instr(6'h0D, 6'h00, 3, 0, -1, -1, 0, "after_abort");

        for (int n = 0; n < 250; n++) begin
            idx = int'($urandom_range(0, 16));
            run_instr(t_op[idx], t_fn[idx], -1, -1, -1, -2, 3, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
